mem_port_arbiter: RTL and testbench

- Shares one memory-side request/response port between NUM_REQ cache controllers, for example separate instruction and data direct-mapped caches.
- Each requester uses the same valid/ready request channel and read-valid/read-ready response channel that the memory presents.
- Round-robin grant; a grant is held until that requester's transaction fully completes.
- Sits between the cache controllers and the memory model/controller.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Holds the FSM state enum, the op encodings and the index-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  // A single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the first set request after i_last_grant, wrapping.
// Produces a one-hot grant, its index, and whether any request is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any_req
);

  always_comb begin
    int best_d;
    int d;
    best_d      = NUM_REQ;
    d           = 0;
    o_grant_idx = '0;
    // d is the distance of requester i from the slot after the last grant.
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i - int'(i_last_grant) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (i_req[i] && (d < best_d)) begin
        best_d      = d;
        o_grant_idx = IDX_W'(i);
      end
    end
    o_any_req  = |i_req;
    o_grant_oh = o_any_req ? (NUM_REQ'(1) << o_grant_idx) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port among NUM_REQ cache controllers.
// Round-robin grant, held until the granted transaction fully completes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDRESS_WIDTH = 64,
  parameter  int DATA_WIDTH    = 512,
  parameter  int NUM_REQ       = 2,
  localparam int REQ_IDX_W     = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_rd_wr,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_write_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_req_read_data,
  output logic [NUM_REQ-1:0]            o_req_read_valid,
  input  logic [NUM_REQ-1:0]            i_req_read_ready,
  output logic                          o_mem_valid,
  output logic                          o_mem_rd_wr,
  output logic [ADDRESS_WIDTH-1:0]      o_mem_address,
  output logic [DATA_WIDTH-1:0]         o_mem_write_data,
  input  logic                          i_mem_ready,
  input  logic [DATA_WIDTH-1:0]         i_mem_read_data,
  input  logic                          i_mem_read_valid,
  output logic                          o_mem_read_ready,
  output logic [REQ_IDX_W-1:0]          o_grant_idx,
  output logic                          o_busy
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid and its payload stay stable until that edge. o_req_ready is a one-cycle completion pulse.

  arb_state_t                r_state, w_state_nxt;
  logic [REQ_IDX_W-1:0]      r_grant, r_last;
  logic [NUM_REQ-1:0]        r_grant_oh;
  logic                      r_rd_wr;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic                      r_mem_valid;
  logic [NUM_REQ-1:0]        r_req_ready;

  logic [NUM_REQ-1:0]        w_arb_oh;
  logic [REQ_IDX_W-1:0]      w_arb_idx;
  logic                      w_any_req;
  logic                      w_latch, w_mem_hs, w_done, w_in_rd;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_rr_arbiter (
    .i_req        (i_req_valid),
    .i_last_grant (r_last),
    .o_grant_oh   (w_arb_oh),
    .o_grant_idx  (w_arb_idx),
    .o_any_req    (w_any_req)
  );

  assign w_in_rd  = (r_state == RD_WAIT);
  assign w_mem_hs = (r_state == REQ) && i_mem_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_latch     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          case (r_rd_wr)
            MEM_RD: w_state_nxt = RD_WAIT;
            MEM_WR: begin
              w_done      = 1'b1;
              w_state_nxt = IDLE;
            end
          endcase
        end
      end
      RD_WAIT: begin
        if (i_mem_read_valid && |(i_req_read_ready & r_grant_oh)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= '0;
      r_grant_oh  <= '0;
      r_last      <= REQ_IDX_W'(NUM_REQ - 1);
      r_rd_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_valid <= 1'b0;
      r_req_ready <= '0;
    end else begin
      r_req_ready <= '0;
      // Latched payload is committed; later requester changes are ignored.
      if (w_latch) begin
        r_grant     <= w_arb_idx;
        r_grant_oh  <= w_arb_oh;
        r_rd_wr     <= i_req_rd_wr[w_arb_idx];
        r_addr      <= i_req_address[int'(w_arb_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        r_wdata     <= i_req_write_data[int'(w_arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        r_mem_valid <= 1'b1;
      end
      if (w_mem_hs) r_mem_valid <= 1'b0;
      if (w_done) begin
        r_req_ready <= r_grant_oh;
        r_last      <= r_grant;
      end
    end
  end

  assign o_mem_valid      = r_mem_valid;
  assign o_mem_rd_wr      = r_rd_wr;
  assign o_mem_address    = r_addr;
  assign o_mem_write_data = r_wdata;
  assign o_req_ready      = r_req_ready;
  assign o_grant_idx      = r_grant;
  assign o_busy           = (r_state != IDLE);
  // Response path is only live while waiting for read data.
  assign o_mem_read_ready = w_in_rd && |(i_req_read_ready & r_grant_oh);
  assign o_req_read_valid = (w_in_rd && i_mem_read_valid) ? r_grant_oh : '0;
  assign o_req_read_data  = w_in_rd ? i_mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: write, backpressured read, contention,
// commit, stray response and asynchronous reset in the middle of a read.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int NR = 2;
  localparam int IW = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_rd_wr, req_read_ready;
  logic [NR*AW-1:0]  req_address;
  logic [NR*DW-1:0]  req_write_data;
  logic [NR-1:0]     req_ready, req_read_valid;
  logic [DW-1:0]     req_read_data;
  logic              mem_valid, mem_rd_wr, mem_ready, mem_read_valid, mem_read_ready;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_write_data, mem_read_data;
  logic [IW-1:0]     grant_idx;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [IW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (req_valid),
    .i_req_rd_wr      (req_rd_wr),
    .i_req_address    (req_address),
    .i_req_write_data (req_write_data),
    .o_req_ready      (req_ready),
    .o_req_read_data  (req_read_data),
    .o_req_read_valid (req_read_valid),
    .i_req_read_ready (req_read_ready),
    .o_mem_valid      (mem_valid),
    .o_mem_rd_wr      (mem_rd_wr),
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_write_data),
    .i_mem_ready      (mem_ready),
    .i_mem_read_data  (mem_read_data),
    .i_mem_read_valid (mem_read_valid),
    .o_mem_read_ready (mem_read_ready),
    .o_grant_idx      (grant_idx),
    .o_busy           (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input int idx, input logic valid, input logic rd_wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid[idx]               = valid;
    req_rd_wr[idx]               = rd_wr;
    req_address[idx*AW +: AW]    = addr;
    req_write_data[idx*DW +: DW] = data;
  endtask

  task automatic clear_inputs();
    req_valid      = '0;
    req_rd_wr      = '0;
    req_address    = '0;
    req_write_data = '0;
    req_read_ready = '0;
    mem_ready      = 1'b0;
    mem_read_valid = 1'b0;
    mem_read_data  = '0;
  endtask

  task automatic wait_mem_valid(input string tag);
    int cyc;
    cyc = 0;
    while (!mem_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check(tag, (cyc < 20), 1'b1);
  endtask

  initial begin
    logic [NR-1:0] oh;
    logic [IW-1:0] g;
    logic [DW-1:0] a5;
    a5    = {64{8'hA5}};
    rst_n = 1'b0;
    clear_inputs();
    #3;
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_idx, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    #9 rst_n = 1'b1;
    tick();

    // single write from requester 0
    drive_req(0, 1'b1, 1'b1, 64'h1000, a5);
    tick();
    check("wr_mem_valid", mem_valid, 1'b1);
    check("wr_addr", mem_address, 64'h1000);
    check("wr_op", mem_rd_wr, 1'b1);
    check("wr_data", mem_write_data, a5);
    check("wr_grant", grant_idx, 1'b0);
    req_valid = '0;
    tick();
    check("wr_hold_valid", mem_valid, 1'b1);
    check("wr_hold_ready", req_ready, 2'b00);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wr_done_ready", req_ready, 2'b01);
    check("wr_done_valid", mem_valid, 1'b0);
    tick();
    check("wr_pulse_once", req_ready, 2'b00);
    check("wr_idle", busy, 1'b0);

    // read from requester 1 with response backpressure
    drive_req(1, 1'b1, 1'b0, 64'h40, '0);
    tick();
    check("rd_mem_valid", mem_valid, 1'b1);
    check("rd_addr", mem_address, 64'h40);
    check("rd_op", mem_rd_wr, 1'b0);
    check("rd_grant", grant_idx, 1'b1);
    req_valid = '0;
    mem_ready = 1'b1;
    tick();
    mem_ready      = 1'b0;
    mem_read_valid = 1'b1;
    mem_read_data  = DW'(16'h1234);
    #1;
    check("rd_wait_busy", busy, 1'b1);
    check("rd_wait_mem_valid", mem_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("rd_bp_valid", req_read_valid, 2'b10);
      check("rd_bp_mem_ready", mem_read_ready, 1'b0);
      check("rd_bp_data", req_read_data, DW'(16'h1234));
      check("rd_bp_no_done", req_ready, 2'b00);
      tick();
    end
    req_read_ready = 2'b10;
    #1;
    check("rd_mem_read_ready", mem_read_ready, 1'b1);
    tick();
    mem_read_valid = 1'b0;
    req_read_ready = '0;
    #1;
    check("rd_done_ready", req_ready, 2'b10);
    check("rd_done_idle", busy, 1'b0);
    check("rd_valid_clear", req_read_valid, 2'b00);
    tick();
    check("rd_pulse_once", req_ready, 2'b00);

    // stray response in IDLE
    mem_read_valid = 1'b1;
    mem_read_data  = DW'(32'hDEAD);
    req_read_ready = 2'b11;
    #1;
    check("stray_valid", req_read_valid, 2'b00);
    check("stray_mem_ready", mem_read_ready, 1'b0);
    tick();
    check("stray_idle", busy, 1'b0);
    check("stray_no_done", req_ready, 2'b00);
    clear_inputs();

    // contention: last grant was 1, so order is 0,1,0,1
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    drive_req(0, 1'b1, 1'b1, 64'h100, '0);
    drive_req(1, 1'b1, 1'b1, 64'h200, '0);
    for (int t = 0; t < 4; t++) begin
      wait_mem_valid("cont_wait");
      g  = exp_q.pop_front();
      oh = 2'b01 << g;
      check("cont_grant", grant_idx, g);
      check("cont_addr", mem_address, (g == 1'b1) ? 64'h200 : 64'h100);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      if (t == 3) req_valid = '0;
      check("cont_ready", req_ready, oh);
    end
    tick();
    check("cont_idle", busy, 1'b0);

    // commit: requester 0 changes address and drops valid while in REQ
    drive_req(0, 1'b1, 1'b1, 64'h80, a5);
    tick();
    check("commit_addr", mem_address, 64'h80);
    drive_req(0, 1'b0, 1'b1, 64'hC0, '0);
    tick();
    check("commit_hold_addr", mem_address, 64'h80);
    check("commit_hold_valid", mem_valid, 1'b1);
    check("commit_hold_data", mem_write_data, a5);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("commit_done", req_ready, 2'b01);

    // reset in the middle of a read from requester 1
    drive_req(1, 1'b1, 1'b0, 64'h300, '0);
    tick();
    req_valid = '0;
    mem_ready = 1'b1;
    tick();
    mem_ready      = 1'b0;
    mem_read_valid = 1'b1;
    mem_read_data  = DW'(16'h5555);
    #1;
    check("rst_mid_rd_valid", req_read_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rvalid", req_read_valid, 2'b00);
    check("rst_mid_rdata", req_read_data, '0);
    check("rst_mid_mem_rready", mem_read_ready, 1'b0);
    check("rst_mid_mem_valid", mem_valid, 1'b0);
    check("rst_mid_addr", mem_address, '0);
    check("rst_mid_grant", grant_idx, 1'b0);
    clear_inputs();
    #3 rst_n = 1'b1;
    drive_req(0, 1'b1, 1'b1, 64'h500, '0);
    drive_req(1, 1'b1, 1'b1, 64'h600, '0);
    tick();
    check("post_rst_grant", grant_idx, 1'b0);
    check("post_rst_addr", mem_address, 64'h500);
    req_valid = '0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("post_rst_done", req_ready, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
